dvp_capture: RTL
================

DVP_CAPTURE -- requirements
Module: dvp_capture

Interface
REQ-001 Parameter DW, default 8: sensor data bus width in bits.
REQ-002 Parameter BPP, default 2, legal 1..3: bus beats per pixel.
REQ-003 Parameter SKIP_FRAMES, default 10, legal 0..255: frames discarded after reset before capture.
REQ-004 Parameter H_ACT, default 640, legal 1..4095: expected pixels per line.
REQ-005 Parameter V_ACT, default 480, legal 1..4095: expected lines per frame.
REQ-006 ov5640_pclk  in  1  sole clock; all logic on rising edge.
REQ-007 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-008 cap_en  in  1  capture enable, sampled only at frame start.
REQ-009 ov5640_vsync  in  1  frame sync, high = vertical blanking.
REQ-010 ov5640_href  in  1  line valid, high = active bytes.
REQ-011 ov5640_data  in  DW  sensor byte.
REQ-012 pix_valid  out  1  pix_data/pix_x/pix_y/pix_sof/pix_sol valid this cycle.
REQ-013 pix_data  out  DW*BPP  assembled pixel, first beat in MSBs.
REQ-014 pix_sof  out  1  with pix_valid: first pixel of frame.
REQ-015 pix_sol  out  1  with pix_valid: first pixel of line.
REQ-016 pix_x  out  12  pixel column, 0-based; pix_y  out  12  line row, 0-based.
REQ-017 line_err  out  1  one-cycle pulse: bad line length or partial pixel.
REQ-018 frame_done  out  1  one-cycle pulse: captured frame ended.
REQ-019 frame_err  out  1  with frame_done: line count != V_ACT.

Function
REQ-020 Frame start: ov5640_vsync high in current cycle and low in previous cycle; vsync registered once for edge detection.
REQ-021 Skip counter: increments at each frame start, saturates at SKIP_FRAMES.
REQ-022 Frame start with skip counter == SKIP_FRAMES and cap_en=1: active flag set from next cycle; otherwise active flag cleared.
REQ-023 Active flag held until next frame start; cap_en deasserted mid-frame does not truncate the current frame.
REQ-024 Beat qualification: ov5640_href=1 and ov5640_vsync=0 and active flag=1; other beats ignored.
REQ-025 Beat counter 0..BPP-1 advances per qualified beat, wraps to 0 after BPP-1; cleared whenever href=0.
REQ-026 On qualified beat with beat counter = BPP-1: pixel = {previous BPP-1 beats, current beat}; pix_valid=1 on the following cycle (latency 1 clock from last beat's sampling edge).
REQ-027 pix_valid is a single-cycle pulse per pixel; BPP=1 permits continuous pix_valid.
REQ-028 pix_data, pix_x, pix_y hold their last values while pix_valid=0.
REQ-029 pix_x: 0 for first pixel of each line, +1 per pixel, saturates at 4095.
REQ-030 pix_y: 0 for first line after frame start, +1 at each href falling edge that closed a line with at least one pixel, saturates at 4095.
REQ-031 pix_sol=1 when pix_x=0; pix_sof=1 when pix_x=0 and pix_y=0.
REQ-032 Href falling edge in active frame: line_err pulses next cycle if pixel count != H_ACT or beat counter != 0; partial pixel discarded, never emitted.
REQ-033 Frame start while active flag=1: frame_done pulses next cycle; frame_err=1 in same cycle if completed line count != V_ACT, else 0.
REQ-034 Frame start cycle clears line counter and pixel counter regardless of href.
REQ-035 Frame end without any lines (vsync toggles only): frame_done=1, frame_err=1 (V_ACT>=1).

Reset
REQ-036 sys_rst_n=0 at a rising edge: all outputs 0, skip counter 0, active flag 0, beat/pixel/line counters 0, vsync register 0.
REQ-037 Reset mid-frame: partial pixel and frame discarded, no frame_done; SKIP_FRAMES frames skipped again after release.

Verification
REQ-038 SKIP_FRAMES=2, cap_en=1, 4 frames of 4x2 px: no pix_valid in frames 1-2; frames 3-4 each 8 pix_valid, one frame_done, frame_err=0 with V_ACT=2, H_ACT=4.
REQ-039 BPP=2, beats 0xAB,0xCD: pix_data=0xABCD one cycle after 0xCD sampled, pix_sof=1, pix_x=0, pix_y=0.
REQ-040 BPP=3, href high 7 beats: two pixels emitted, last beat dropped, line_err=1 one cycle after href falls.
REQ-041 cap_en=0 at frame start, 1 mid-frame: no pixels that frame; capture starts at next frame start.
REQ-042 H_ACT=4, line of 3 pixels: line_err pulse; V_ACT=2 with 3 lines: frame_err=1 with frame_done.
REQ-043 sys_rst_n low mid-line: outputs 0 next cycle, no pixel for interrupted line, skip count restarts.

Source files
------------

// File: rtl/dvp_capture.sv
// DVP camera capture: qualifies sensor beats, assembles BPP-beat pixels with
// x/y coordinates, skips start-up frames and flags bad line/frame geometry.
module dvp_capture #(
  parameter int DW          = 8,
  parameter int BPP         = 2,
  parameter int SKIP_FRAMES = 10,
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480
) (
  input  logic              ov5640_pclk,
  input  logic              sys_rst_n,
  input  logic              cap_en,
  input  logic              ov5640_vsync,
  input  logic              ov5640_href,
  input  logic [DW-1:0]     ov5640_data,
  output logic              pix_valid,
  output logic [DW*BPP-1:0] pix_data,
  output logic              pix_sof,
  output logic              pix_sol,
  output logic [11:0]       pix_x,
  output logic [11:0]       pix_y,
  output logic              line_err,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int          PW        = DW * BPP;
  localparam logic [1:0]  LAST_BEAT = 2'(BPP - 1);
  localparam logic [7:0]  SKIP_MAX  = 8'(SKIP_FRAMES);
  localparam logic [12:0] H_ACT_W   = 13'(H_ACT);
  localparam logic [12:0] V_ACT_W   = 13'(V_ACT);
  // Counters run one past the 12-bit range so a 4096+ pixel line never
  // aliases onto H_ACT=4095.
  localparam logic [12:0] CNT_SAT   = 13'h1000;

  function automatic logic [11:0] sat12(input logic [12:0] v);
    return v[12] ? 12'hFFF : v[11:0];
  endfunction

  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    skip_q, skip_d;
  logic          active_q, active_d;
  logic [1:0]    beat_q, beat_d;
  logic [DW-1:0] beat_buf_q [BPP];
  logic [DW-1:0] beat_buf_d [BPP];
  logic [12:0]   pix_cnt_q, pix_cnt_d;
  logic [12:0]   line_cnt_q, line_cnt_d;

  logic          pix_valid_q, pix_valid_d;
  logic [PW-1:0] pix_data_q, pix_data_d;
  logic          pix_sof_q, pix_sof_d;
  logic          pix_sol_q, pix_sol_d;
  logic [11:0]   pix_x_q, pix_x_d;
  logic [11:0]   pix_y_q, pix_y_d;
  logic          line_err_q, line_err_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;

  logic          frame_start;
  logic          beat_ok;
  logic          last_beat;
  logic          line_end;
  logic [PW-1:0] pixel_asm;

  always_comb begin
    frame_start = ov5640_vsync && !vsync_q;
    beat_ok     = ov5640_href && !ov5640_vsync && active_q;
    last_beat   = beat_ok && (beat_q == LAST_BEAT);
    line_end    = href_q && !ov5640_href && active_q;
  end

  // Earlier beats are buffered; the closing beat is taken straight off the bus.
  always_comb begin
    pixel_asm = '0;
    for (int i = 0; i < BPP; i++) begin
      if (i == BPP - 1) begin
        pixel_asm[(BPP-1-i)*DW +: DW] = ov5640_data;
      end else begin
        pixel_asm[(BPP-1-i)*DW +: DW] = beat_buf_q[i];
      end
    end
  end

  always_comb begin
    vsync_d      = ov5640_vsync;
    href_d       = ov5640_href;
    skip_d       = skip_q;
    active_d     = active_q;
    beat_d       = beat_q;
    beat_buf_d   = beat_buf_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    pix_valid_d  = 1'b0;
    pix_sof_d    = 1'b0;
    pix_sol_d    = 1'b0;
    pix_data_d   = pix_data_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    line_err_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    if (!ov5640_href) begin
      beat_d = 2'd0;
    end else if (beat_ok) begin
      for (int i = 0; i < BPP; i++) begin
        if (beat_q == 2'(i)) begin
          beat_buf_d[i] = ov5640_data;
        end
      end
      beat_d = (beat_q == LAST_BEAT) ? 2'd0 : beat_q + 2'd1;
    end

    if (last_beat) begin
      pix_valid_d = 1'b1;
      pix_data_d  = pixel_asm;
      pix_x_d     = sat12(pix_cnt_q);
      pix_y_d     = sat12(line_cnt_q);
      pix_sol_d   = (pix_cnt_q == 13'd0);
      pix_sof_d   = (pix_cnt_q == 13'd0) && (line_cnt_q == 13'd0);
      if (pix_cnt_q != CNT_SAT) begin
        pix_cnt_d = pix_cnt_q + 13'd1;
      end
    end

    // A leftover beat count at href fall means a partial pixel was dropped.
    if (line_end) begin
      line_err_d = (pix_cnt_q != H_ACT_W) || (beat_q != 2'd0);
      pix_cnt_d  = 13'd0;
      if ((pix_cnt_q != 13'd0) && (line_cnt_q != CNT_SAT)) begin
        line_cnt_d = line_cnt_q + 13'd1;
      end
    end

    if (frame_start) begin
      frame_done_d = active_q;
      frame_err_d  = active_q && (line_cnt_q != V_ACT_W);
      active_d     = cap_en && (skip_q == SKIP_MAX);
      if (skip_q != SKIP_MAX) begin
        skip_d = skip_q + 8'd1;
      end
      pix_cnt_d  = 13'd0;
      line_cnt_d = 13'd0;
    end
  end

  always_ff @(posedge ov5640_pclk) begin
    if (!sys_rst_n) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      skip_q       <= 8'd0;
      active_q     <= 1'b0;
      beat_q       <= 2'd0;
      for (int i = 0; i < BPP; i++) begin
        beat_buf_q[i] <= '0;
      end
      pix_cnt_q    <= 13'd0;
      line_cnt_q   <= 13'd0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_sof_q    <= 1'b0;
      pix_sol_q    <= 1'b0;
      pix_x_q      <= 12'd0;
      pix_y_q      <= 12'd0;
      line_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      skip_q       <= skip_d;
      active_q     <= active_d;
      beat_q       <= beat_d;
      beat_buf_q   <= beat_buf_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_sof_q    <= pix_sof_d;
      pix_sol_q    <= pix_sol_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      line_err_q   <= line_err_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_sof    = pix_sof_q;
  assign pix_sol    = pix_sol_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign line_err   = line_err_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule
